// File: rtl/i2s_master.sv
// Free-running I2S transmitter: derives SCK/BCK/LCK from a 9-bit frame counter and
// serialises the captured mono sample MSB-first into both stereo slots.
module i2s_master (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic [15:0] SMP,
    output logic        SCK,
    output logic        BCK,
    output logic        LCK,
    output logic        DIN
);

    localparam int unsigned CNT_W = 9;
    localparam int unsigned SMP_W = 16;
    localparam int unsigned POS_W = 5;
    localparam int unsigned IDX_W = 4;

    logic [CNT_W-1:0] r_cnt;
    logic [SMP_W-1:0] r_shadow;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_wrap;
    logic [POS_W-1:0] w_pos;
    logic [IDX_W-1:0] w_bit_idx;
    logic             w_din_nxt;

    // Decode the upcoming counter value so outputs match cnt right after each edge.
    always_comb begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        w_wrap    = (w_cnt_nxt == '0);
        w_pos     = w_cnt_nxt[7:3];
        w_bit_idx = IDX_W'(POS_W'(16) - w_pos);
        w_din_nxt = 1'b0;
        if ((w_pos >= POS_W'(1)) && (w_pos <= POS_W'(16))) begin
            w_din_nxt = r_shadow[w_bit_idx];
        end
    end

    // Counter, sample shadow and registered interface outputs.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_cnt    <= '0;
            r_shadow <= '0;
            SCK      <= 1'b0;
            BCK      <= 1'b0;
            LCK      <= 1'b0;
            DIN      <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_wrap) begin
                r_shadow <= SMP;
            end
            SCK <= w_cnt_nxt[0];
            BCK <= w_cnt_nxt[2];
            LCK <= w_cnt_nxt[8];
            DIN <= w_din_nxt;
        end
    end

endmodule

// File: tb/tb_i2s_master.sv
// Directed bench for i2s_master: clock ratios, bit patterns per slot, sample capture
// timing and asynchronous reset behaviour.
module tb_i2s_master;

    logic        CLK;
    logic        RESETn;
    logic [15:0] SMP;
    logic        SCK;
    logic        BCK;
    logic        LCK;
    logic        DIN;

    i2s_master dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .SMP    (SMP),
        .SCK    (SCK),
        .BCK    (BCK),
        .LCK    (LCK),
        .DIN    (DIN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0]  tb_cnt;
    int          tb_total;
    logic [31:0] left_w;
    logic [31:0] right_w;
    logic        prev_sck, prev_bck, prev_lck, prev_din;
    int          last_bck_rise, last_lck_rise;
    int          sck_bad, dec_bad, bck_rises, bck_high, bck_per_bad;
    int          lck_high, lck_rises, lck_per_bad, lck_bad, din_bad, din_ones;
    int          s_sck_bad, s_bck_rises, s_bck_high, s_bck_per_bad;
    int          s_lck_high, s_lck_rises, s_lck_per_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_prev();
        tb_cnt        = '0;
        prev_sck      = 1'b0;
        prev_bck      = 1'b0;
        prev_lck      = 1'b0;
        prev_din      = 1'b0;
        last_bck_rise = -1;
        last_lck_rise = -1;
    endtask

    // One clock: advance the bench's own cycle count and accumulate observations.
    task automatic tick();
        @(posedge CLK);
        #1;
        tb_cnt   = tb_cnt + 9'd1;
        tb_total = tb_total + 1;
        if (SCK == prev_sck) sck_bad++;
        if (SCK !== tb_cnt[0] || BCK !== tb_cnt[2] || LCK !== tb_cnt[8]) dec_bad++;
        if (BCK) bck_high++;
        if (BCK && !prev_bck) begin
            bck_rises++;
            if (last_bck_rise >= 0 && (tb_total - last_bck_rise) != 8) bck_per_bad++;
            last_bck_rise = tb_total;
        end
        if (LCK) lck_high++;
        if (LCK && !prev_lck) begin
            lck_rises++;
            if (last_lck_rise >= 0 && (tb_total - last_lck_rise) != 512) lck_per_bad++;
            last_lck_rise = tb_total;
        end
        if ((LCK != prev_lck) && !(prev_bck && !BCK)) lck_bad++;
        if ((DIN != prev_din) && (tb_cnt[2:0] != 3'd0)) din_bad++;
        if (DIN) din_ones++;
        if (tb_cnt[2:0] == 3'd4) begin
            if (!tb_cnt[8]) left_w[31 - int'(tb_cnt[7:3])] = DIN;
            else            right_w[31 - int'(tb_cnt[7:3])] = DIN;
        end
        prev_sck = SCK;
        prev_bck = BCK;
        prev_lck = LCK;
        prev_din = DIN;
        if (tb_total == 2048) begin
            s_sck_bad     = sck_bad;
            s_bck_rises   = bck_rises;
            s_bck_high    = bck_high;
            s_bck_per_bad = bck_per_bad;
            s_lck_high    = lck_high;
            s_lck_rises   = lck_rises;
            s_lck_per_bad = lck_per_bad;
        end
    endtask

    // Collect one frame starting at cnt==0; optionally change SMP at cnt==chg_at.
    task automatic run_frame(input int chg_at, input logic [15:0] chg_val);
        left_w   = '0;
        right_w  = '0;
        din_ones = 0;
        for (int i = 0; i < 511; i++) begin
            tick();
            if (chg_at >= 0 && int'(tb_cnt) == chg_at) SMP = chg_val;
        end
    endtask

    initial begin
        tb_total = 0;
        {sck_bad, dec_bad, bck_rises, bck_high, bck_per_bad} = '0;
        {lck_high, lck_rises, lck_per_bad, lck_bad, din_bad, din_ones} = '0;
        {s_sck_bad, s_bck_rises, s_bck_high, s_bck_per_bad} = '0;
        {s_lck_high, s_lck_rises, s_lck_per_bad} = '0;
        left_w  = '0;
        right_w = '0;
        clear_prev();

        RESETn = 1'b0;
        SMP    = 16'h8001;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs", 32'({SCK, BCK, LCK, DIN}), 32'h0);

        @(negedge CLK);
        RESETn = 1'b1;
        tick();
        chk("first_edge_sck", 32'(SCK), 32'h1);

        // Frame 0 after release: shadow is still zero.
        din_ones = 0;
        for (int i = 0; i < 510; i++) tick();
        chk("first_frame_silent", 32'(din_ones), 32'h0);
        tick();
        chk("wrap_outputs", 32'({SCK, BCK, LCK, DIN}), 32'h0);

        // Frame 1 sends 0x8001; SMP change right after capture must not leak in.
        SMP = 16'hFFFF;
        run_frame(-1, 16'h0);
        chk("p8001_left", left_w, 32'h4000_8000);
        chk("p8001_right", right_w, 32'h4000_8000);
        tick();

        SMP = 16'h1234;
        run_frame(-1, 16'h0);
        chk("pFFFF_left", left_w, 32'h7FFF_8000);
        chk("pFFFF_right", right_w, 32'h7FFF_8000);
        tick();

        run_frame(100, 16'hABCD);
        chk("p1234_left", left_w, 32'h091A_0000);
        chk("p1234_right", right_w, 32'h091A_0000);
        tick();

        run_frame(-1, 16'h0);
        chk("pABCD_left", left_w, 32'h55E6_8000);
        chk("pABCD_right", right_w, 32'h55E6_8000);

        chk("sck_toggle_bad", 32'(s_sck_bad), 32'd0);
        chk("bck_rises", 32'(s_bck_rises), 32'd256);
        chk("bck_high", 32'(s_bck_high), 32'd1024);
        chk("bck_period_bad", 32'(s_bck_per_bad), 32'd0);
        chk("lck_rises", 32'(s_lck_rises), 32'd4);
        chk("lck_high", 32'(s_lck_high), 32'd1024);
        chk("lck_period_bad", 32'(s_lck_per_bad), 32'd0);

        // Mid-frame reset at cnt==300, where BCK and LCK are both high.
        tick();
        for (int i = 0; i < 300; i++) tick();
        chk("pre_reset_bck_lck", 32'({BCK, LCK}), 32'h3);
        RESETn = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({SCK, BCK, LCK, DIN}), 32'h0);
        repeat (4) @(posedge CLK);
        #1;
        chk("held_reset_outputs", 32'({SCK, BCK, LCK, DIN}), 32'h0);

        SMP = 16'h5555;
        @(negedge CLK);
        RESETn = 1'b1;
        clear_prev();
        din_ones = 0;
        for (int i = 0; i < 511; i++) tick();
        chk("post_reset_silent", 32'(din_ones), 32'h0);
        tick();
        run_frame(-1, 16'h0);
        chk("p5555_left", left_w, 32'h2AAA_8000);
        chk("p5555_right", right_w, 32'h2AAA_8000);

        chk("decode_bad", 32'(dec_bad), 32'd0);
        chk("lck_not_on_bck_fall", 32'(lck_bad), 32'd0);
        chk("din_off_boundary", 32'(din_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
